// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined 32-bit add/subtract unit.
package addsub_pkg;
   localparam int ADDSUB_WIDTH = 32;
   localparam int ADDSUB_HALF  = 16;

   typedef enum logic [1:0] {
      ADD  = 2'b00,
      SUB  = 2'b01,
      SLT  = 2'b10,
      SLTU = 2'b11
   } addsub_op_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } addsub_flags_t;
endpackage

// File: rtl/CLA_16bit.sv
// 16-bit carry-lookahead adder built from four 4-bit groups; o_g is the
// carry-out of the whole block, including the effect of i_cin.
module CLA_16bit (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_cin,
   output logic [15:0] o_sum,
   output logic        o_g
);
   logic [15:0] w_g, w_p, w_c;
   logic [3:0]  w_gg, w_gp;
   logic [4:0]  w_cg;

   always_comb begin
      w_g  = i_a & i_b;
      w_p  = i_a ^ i_b;
      w_gg = '0;
      w_gp = '0;
      w_cg = '0;
      w_c  = '0;
      for (int k = 0; k < 4; k++) begin
         w_gg[k] = w_g[4*k+3]
                 | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
         w_gp[k] = &w_p[4*k +: 4];
      end
      w_cg[0] = i_cin;
      for (int k = 0; k < 4; k++)
         w_cg[k+1] = w_gg[k] | (w_gp[k] & w_cg[k]);
      // Group carries are looked ahead; bits inside a group ripple from them.
      for (int k = 0; k < 4; k++) begin
         w_c[4*k] = w_cg[k];
         for (int j = 1; j < 4; j++)
            w_c[4*k+j] = w_g[4*k+j-1] | (w_p[4*k+j-1] & w_c[4*k+j-1]);
      end
   end

   assign o_sum = w_p ^ w_c;
   assign o_g   = w_cg[4];
endmodule

// File: rtl/addsub_pipe32.sv
// Two-stage 32-bit ADD/SUB/SLT/SLTU unit: low half in stage 1, high half in stage 2.
// Define ADDSUB_SLT_EN to get 0/1 SLT/SLTU results; otherwise those ops act as SUB.
module addsub_pipe32
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic [TAG_W-1:0] out_tag
);
   localparam int HALF = WIDTH / 2;

   if (WIDTH != ADDSUB_WIDTH) begin : g_bad_width
      $error("addsub_pipe32: only WIDTH=32 is supported");
   end

   logic             w_sub, w_accept, w_s2_adv, w_c16, w_c32;
   logic [WIDTH-1:0] w_bx, w_raw, w_result;
   logic [HALF-1:0]  w_sum_lo, w_sum_hi;
   addsub_flags_t    w_flags;

   logic             r_s1_valid, r_s1_c16;
   logic [HALF-1:0]  r_s1_sum_lo, r_s1_a_hi, r_s1_bx_hi;
   logic [TAG_W-1:0] r_s1_tag;
`ifdef ADDSUB_SLT_EN
   addsub_op_e       r_s1_op;
`endif

   logic             r_s2_valid;
   logic [WIDTH-1:0] r_result;
   addsub_flags_t    r_flags;
   logic [TAG_W-1:0] r_tag;

   assign w_s2_adv = !r_s2_valid || out_ready;
   assign in_ready = !r_s1_valid || w_s2_adv;
   assign w_accept = in_valid && in_ready;

   // Subtraction is A + ~B + 1, with the +1 entering as the low-half carry-in.
   assign w_sub = (in_op != ADD);
   assign w_bx  = w_sub ? ~in_b : in_b;

   CLA_16bit u_cla_lo (
      .i_a   (in_a[HALF-1:0]),
      .i_b   (w_bx[HALF-1:0]),
      .i_cin (w_sub),
      .o_sum (w_sum_lo),
      .o_g   (w_c16)
   );

   // Stage 1: low-half sum and carry, high-half operands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_c16    <= 1'b0;
         r_s1_sum_lo <= '0;
         r_s1_a_hi   <= '0;
         r_s1_bx_hi  <= '0;
         r_s1_tag    <= '0;
`ifdef ADDSUB_SLT_EN
         r_s1_op     <= ADD;
`endif
      end else if (w_accept) begin
         r_s1_valid  <= 1'b1;
         r_s1_c16    <= w_c16;
         r_s1_sum_lo <= w_sum_lo;
         r_s1_a_hi   <= in_a[WIDTH-1:HALF];
         r_s1_bx_hi  <= w_bx[WIDTH-1:HALF];
         r_s1_tag    <= in_tag;
`ifdef ADDSUB_SLT_EN
         r_s1_op     <= addsub_op_e'(in_op);
`endif
      end else if (w_s2_adv) begin
         r_s1_valid  <= 1'b0;
      end
   end

   CLA_16bit u_cla_hi (
      .i_a   (r_s1_a_hi),
      .i_b   (r_s1_bx_hi),
      .i_cin (r_s1_c16),
      .o_sum (w_sum_hi),
      .o_g   (w_c32)
   );

   assign w_raw     = {w_sum_hi, r_s1_sum_lo};
   assign w_flags.n = w_raw[WIDTH-1];
   assign w_flags.z = (w_raw == '0);
   assign w_flags.c = w_c32;
   assign w_flags.v = (r_s1_a_hi[HALF-1] == r_s1_bx_hi[HALF-1]) &&
                      (w_raw[WIDTH-1] != r_s1_a_hi[HALF-1]);

`ifdef ADDSUB_SLT_EN
   always_comb begin
      w_result = w_raw;
      case (r_s1_op)
         SLT:     w_result = {{(WIDTH-1){1'b0}}, w_flags.n ^ w_flags.v};
         SLTU:    w_result = {{(WIDTH-1){1'b0}}, !w_flags.c};
         default: w_result = w_raw;
      endcase
   end
`else
   assign w_result = w_raw;
`endif

   // Stage 2: high-half sum, flags and final result; holds under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_result   <= '0;
         r_flags    <= '0;
         r_tag      <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_result <= w_result;
            r_flags  <= w_flags;
            r_tag    <= r_s1_tag;
         end
      end
   end

   assign out_valid  = r_s2_valid;
   assign out_result = r_result;
   assign out_flags  = r_flags;
   assign out_tag    = r_tag;
endmodule

// File: tb/tb_addsub_pipe32.sv
// Directed and random-stream bench for addsub_pipe32 (honours ADDSUB_SLT_EN).
module tb_addsub_pipe32;
   logic        clk, rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [1:0]  in_op;
   logic [31:0] in_a, in_b, out_result;
   logic [3:0]  out_flags;
   logic [4:0]  in_tag, out_tag;

   int n_cmp = 0;
   int n_bad = 0;

   addsub_pipe32 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .out_tag    (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef ADDSUB_SLT_EN
   localparam bit SLT_ON = 1'b1;
`else
   localparam bit SLT_ON = 1'b0;
`endif

   // Independent model: plain 33-bit add/sub, signed/unsigned compares.
   function automatic logic [40:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] tag);
      logic [32:0] s;
      logic [31:0] res;
      logic        n, z, c, v;
      if (op == 2'b00) begin
         s = {1'b0, a} + {1'b0, b};
         c = s[32];
         v = (a[31] == b[31]) && (s[31] != a[31]);
      end else begin
         s = {1'b0, a} - {1'b0, b};
         c = (a >= b);
         v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      n = s[31];
      z = (s[31:0] == 32'd0);
      res = s[31:0];
      if (SLT_ON && op == 2'b10) res = {31'd0, ($signed(a) < $signed(b))};
      if (SLT_ON && op == 2'b11) res = {31'd0, (a < b)};
      return {tag, n, z, c, v, res};
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Drives one op into an empty pipe with out_ready=1 and samples after 1 and 2 cycles.
   task automatic issue_single(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag, output logic v_mid, output logic v_out,
                               output logic [31:0] res, output logic [3:0] fl, output logic [4:0] tg);
      @(negedge clk);
      in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      v_mid = out_valid;
      @(negedge clk);
      v_out = out_valid; res = out_result; fl = out_flags; tg = out_tag;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", out_result); end
      n_cmp++; if (out_flags !== 4'd0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", out_flags); end
      n_cmp++; if (out_tag !== 5'd0) begin n_bad++; $display("FAIL reset_tag: got %0d want 0", out_tag); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_vectors();
      logic [1:0]  ops  [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
      logic [31:0] va   [10] = '{32'h0000FFFF, 32'd5, 32'd5, 32'd5, 32'h7FFFFFFF, 32'hFFFFFFFF,
                                 32'd7, 32'h80000000, 32'h80000000, 32'h80000000};
      logic [31:0] vb   [10] = '{32'd1, 32'd7, 32'd7, 32'd7, 32'd1, 32'd1, 32'd5, 32'd1, 32'd1, 32'd1};
      logic [31:0] eres [10] = '{32'h00010000, 32'hFFFFFFFE,
                                 SLT_ON ? 32'd1 : 32'hFFFFFFFE, SLT_ON ? 32'd1 : 32'hFFFFFFFE,
                                 32'h80000000, 32'h00000000, 32'd2, 32'h7FFFFFFF,
                                 SLT_ON ? 32'd1 : 32'h7FFFFFFF, SLT_ON ? 32'd0 : 32'h7FFFFFFF};
      logic [3:0]  efl  [10] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b0110,
                                 4'b0010, 4'b0011, 4'b0011, 4'b0011};
      logic        vm, vo;
      logic [31:0] r;
      logic [3:0]  f;
      logic [4:0]  t;
      for (int i = 0; i < 10; i++) begin
         issue_single(ops[i], va[i], vb[i], 5'(i + 10), vm, vo, r, f, t);
         n_cmp++; if (vm !== 1'b0) begin n_bad++; $display("FAIL vec%0d_early_valid: got %b want 0", i, vm); end
         n_cmp++; if (vo !== 1'b1) begin n_bad++; $display("FAIL vec%0d_latency: got %b want 1", i, vo); end
         n_cmp++; if (r !== eres[i]) begin n_bad++; $display("FAIL vec%0d_result: got %h want %h", i, r, eres[i]); end
         n_cmp++; if (f !== efl[i]) begin n_bad++; $display("FAIL vec%0d_flags: got %b want %b", i, f, efl[i]); end
         n_cmp++; if (t !== 5'(i + 10)) begin n_bad++; $display("FAIL vec%0d_tag: got %0d want %0d", i, t, i + 10); end
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_r [4] = '{32'h00001001, 32'h00002002, 32'h00003003, 32'h00004004};
      @(negedge clk);
      out_ready = 1'b0;
      in_op = 2'b00; in_a = 32'h1000; in_b = 32'd1; in_tag = 5'd1; in_valid = 1'b1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept1: got %b want 1", in_ready); end
      @(negedge clk);
      in_a = 32'h2000; in_b = 32'd2; in_tag = 5'd2;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept2: got %b want 1", in_ready); end
      @(negedge clk);
      in_a = 32'h3000; in_b = 32'd3; in_tag = 5'd3;
      for (int h = 0; h < 5; h++) begin
         n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall%0d: in_ready got %b want 0", h, in_ready); end
         n_cmp++; if (out_valid !== 1'b1 || out_tag !== 5'd1 || out_result !== exp_r[0]) begin
            n_bad++; $display("FAIL bp_hold%0d: got v%b tag%0d %h want v1 tag1 %h", h, out_valid, out_tag, out_result, exp_r[0]);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (out_valid !== 1'b1 || out_tag !== 5'(k + 1) || out_result !== exp_r[k]) begin
            n_bad++; $display("FAIL bp_order%0d: got v%b tag%0d %h want v1 tag%0d %h", k, out_valid, out_tag, out_result, k + 1, exp_r[k]);
         end
         @(negedge clk);
         if (k == 0) begin in_a = 32'h4000; in_b = 32'd4; in_tag = 5'd4; end
         if (k == 1) in_valid = 1'b0;
      end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_reset_inflight();
      logic        vm, vo;
      logic [31:0] r;
      logic [3:0]  f;
      logic [4:0]  t;
      @(negedge clk);
      out_ready = 1'b0;
      in_op = 2'b00; in_a = 32'd1; in_b = 32'd1; in_tag = 5'd7; in_valid = 1'b1;
      @(negedge clk);
      in_tag = 5'd8;
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_async_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_tag !== 5'd0 || out_result !== 32'd0) begin
         n_bad++; $display("FAIL rst_async_data: got tag%0d %h want tag0 0", out_tag, out_result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stale%0d: got %b want 0", c, out_valid); end
      end
      issue_single(2'b00, 32'd10, 32'd20, 5'd9, vm, vo, r, f, t);
      n_cmp++; if (vm !== 1'b0 || vo !== 1'b1) begin n_bad++; $display("FAIL rst_new_latency: got %b%b want 01", vm, vo); end
      n_cmp++; if (r !== 32'd30 || f !== 4'b0000 || t !== 5'd9) begin
         n_bad++; $display("FAIL rst_new_op: got %h %b %0d want 1e 0000 9", r, f, t);
      end
      @(negedge clk);
   endtask

   task automatic test_random_stream();
      localparam int NOPS = 10000;
      logic [40:0] exp_q[$];
      logic [40:0] e;
      logic        pending = 1'b0;
      int          sent = 0, got = 0, cyc = 0;
      while (got < NOPS && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         if (!pending && sent < NOPS && $urandom_range(0, 3) != 0) begin
            in_op = 2'($urandom_range(0, 3)); in_a = pick_val(); in_b = pick_val();
            in_tag = 5'(sent);
            pending = 1'b1;
         end
         in_valid  = pending;
         out_ready = ($urandom_range(0, 3) != 0);
         #4;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++; $display("FAIL rnd_extra: unexpected result tag%0d", out_tag);
            end else begin
               e = exp_q.pop_front();
               n_cmp++; if ({out_tag, out_flags, out_result} !== e) begin
                  n_bad++; $display("FAIL rnd_op%0d: got tag%0d %b %h want tag%0d %b %h", got, out_tag, out_flags, out_result, e[40:36], e[35:32], e[31:0]);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(in_op, in_a, in_b, in_tag));
            pending = 1'b0;
            sent++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if (got !== NOPS) begin n_bad++; $display("FAIL rnd_timeout: got %0d results want %0d", got, NOPS); end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_op = 2'b00; in_a = 32'd0; in_b = 32'd0; in_tag = 5'd0;
      test_reset();
      test_vectors();
      test_backpressure();
      test_reset_inflight();
      test_random_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/addsub_pipe32.md
Name: addsub_pipe32

Overview:
- Two-stage pipelined 32-bit add/subtract unit for the ALU execute path.
- Feeds two instances of the existing 16-bit carry-lookahead adder (CLA_16bit), one per pipeline stage; the low-half carry-out is registered and drives the high-half carry-in.
- Valid/ready handshake on both sides.
- Produces result, NZCV flags and a passthrough destination tag for writeback.

Parameters:
- WIDTH, 32, operand/result width; only 32 supported (2 x 16-bit halves); elaboration error otherwise.
- HALF, 16, half width; derived as WIDTH/2, not to be overridden.
- TAG_W, 5, width of the destination-register tag carried alongside the operation.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts operation this cycle.
- in_op  in  2  00 ADD, 01 SUB, 10 SLT, 11 SLTU.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  sum/difference, or 0/1 for SLT/SLTU.
- out_flags  out  4  {N,Z,C,V} of the raw add/sub.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_flags=0, out_tag=0; all data registers cleared.
- Reset mid-operation discards both stages; nothing is emitted after release until a new accept.
- Accept: in_valid && in_ready.
  - in_ready = !s1_valid || s2_adv.
  - s2_adv = !s2_valid || out_ready.
  - in_ready is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- Operand prep: sub = (op != ADD). Bx = sub ? ~in_b : in_b. Low-half carry-in = sub.
- Stage 1 (on accept), registers:
  - low sum from the low-half CLA.
  - carry c16 = low-half CLA g output.
  - a_hi, bx_hi, op, tag.
  - s1_valid=1.
- s1_valid clears when stage 2 takes the entry and there is no simultaneous accept.
- Stage 2 (on s1_valid && s2_adv), high-half CLA with Cin = c16. Registers:
  - raw = {sum_hi, sum_lo}.
  - C = carry-out of high half; for SUB, C=1 means no borrow.
  - V = (a[31] == bx[31]) && (raw[31] != a[31]).
  - N = raw[31].
  - Z = (raw == 0).
  - SLT result = N ^ V. SLTU result = !C. Both are zero-extended to 32 bits.
  - Flags always reflect raw for every op.
- Latency: 2 cycles from accept to out_valid with no backpressure. Throughput: 1 op/cycle.
- Backpressure: with out_valid && !out_ready, stage 2 holds and all out_* stay stable.
  - Stage 1 still fills if empty; a third op stalls (in_ready=0).
- Simultaneous stage-2 drain and stage-1 refill in the same cycle: both occur, no bubble inserted.
- Wrap-around: 32-bit modular arithmetic. 0xFFFFFFFF+1 gives raw=0 with C=1, Z=1.
- Order preserved; no reordering, no drop.

Optional Feature:
- ADDSUB_SLT_EN
  - Defined: ops 10/11 produce SLT/SLTU results as above.
  - Undefined: ops 10/11 behave exactly as SUB (result=raw); SLT logic is not synthesised.
  - Flags are identical in both builds.

Decomposition:
- Shared package addsub_pkg:
  - enum addsub_op_e {ADD, SUB, SLT, SLTU} (2-bit).
  - typedef addsub_flags_t packed struct {n,z,c,v}.
  - constants ADDSUB_WIDTH=32, ADDSUB_HALF=16.
- Sub-modules: the two 16-bit adder instances are the existing CLA_16bit. No new sub-module; stage-valid logic stays inline.

Test Plan:
- ADD 0x0000FFFF + 0x00000001, out_ready=1 -> after 2 cycles out_result=0x00010000, flags N0 Z0 C0 V0 (exercises c16 handoff).
- SUB 0x00000005 - 0x00000007 -> 0xFFFFFFFE, N1 Z0 C0 V0. SLT same operands -> 1. SLTU same operands -> 1 (with ADDSUB_SLT_EN). Without the macro, SLT returns 0xFFFFFFFE.
- ADD 0x7FFFFFFF + 1 -> 0x80000000, V1 N1. ADD 0xFFFFFFFF + 1 -> 0, Z1 C1.
- Backpressure: issue 4 back-to-back ops, hold out_ready=0 for 5 cycles.
  - in_ready drops after the 2nd accept; outputs stay stable.
  - On release, results emerge in order with tags 1,2,3,4, one per cycle.
- Assert rst_n low while 2 ops are in flight -> out_valid=0 immediately. After release, no stale result appears; a new op returns in 2 cycles.
- Random stream of 10k ops with random in_valid/out_ready -> result/flags/tag match the reference model and order is preserved.
